// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI command receiver.
// Contents: command FSM state encoding, long-command flag bit index,
// argument byte count and the SUMP opcodes used around the receiver.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_OPCODE = 3'd0,
        ST_ARG0   = 3'd1,
        ST_ARG1   = 3'd2,
        ST_ARG2   = 3'd3,
        ST_ARG3   = 3'd4
    } cmd_state_e;

    // Opcode bit that marks a command carrying a 32-bit argument
    localparam int LONG_BIT  = 7;
    localparam int ARG_BYTES = 4;

    typedef enum logic [7:0] {
        SUMP_RESET       = 8'h00,
        SUMP_RUN         = 8'h01,
        SUMP_ID          = 8'h02,
        SUMP_SET_DIVIDER = 8'h80
    } sump_op_e;

endpackage

// File: rtl/spi_rx_byte.sv
// spi_rx_byte
// Oversampling SPI mode-0 byte receiver (MSB first) running on i_clk.
// Ports:
//   i_clk, i_rst_n   system clock, async active-low reset
//   i_cs_n           SPI chip select (async to i_clk)
//   i_sclk           SPI clock (async to i_clk)
//   i_mosi           SPI data (async to i_clk)
//   o_byte           assembled byte, valid while o_byte_valid is high
//   o_byte_valid     one-cycle strobe on the 8th detected SCLK rising edge
module spi_rx_byte
    import spi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    output logic [7:0] o_byte,
    output logic       o_byte_valid
);

    logic       r_cs_meta;
    logic       r_cs_s;
    logic       r_sclk_meta;
    logic       r_sclk_s;
    logic       r_sclk_d;
    logic       r_mosi_meta;
    logic       r_mosi_s;
    logic [2:0] r_cnt;
    logic [6:0] r_shift;
    logic       w_sclk_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_s      <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_s    <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_s    <= 1'b0;
        end else begin
            r_cs_meta   <= i_cs_n;
            r_cs_s      <= r_cs_meta;
            r_sclk_meta <= i_sclk;
            r_sclk_s    <= r_sclk_meta;
            r_sclk_d    <= r_sclk_s;
            r_mosi_meta <= i_mosi;
            r_mosi_s    <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_s & ~r_sclk_d & ~r_cs_s;

    // Only the first seven bits need storage; the eighth is taken straight
    // from the synchronizer so the byte is available on the detecting cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 3'd0;
            r_shift <= 7'd0;
        end else if (r_cs_s) begin
            r_cnt   <= 3'd0;
            r_shift <= 7'd0;
        end else if (w_sclk_rise) begin
            r_cnt   <= r_cnt + 3'd1;
            r_shift <= {r_shift[5:0], r_mosi_s};
        end
    end

    assign o_byte       = {r_shift, r_mosi_s};
    assign o_byte_valid = w_sclk_rise & (r_cnt == 3'd7);

endmodule

// File: rtl/spi_receiver.sv
// spi_receiver
// Assembles SUMP command bytes received over SPI into opcode/argument pairs.
// Short commands (bit 7 clear) are one byte; long commands carry a 32-bit
// little-endian argument in the following four bytes.
// Optional feature: define SPI_RECEIVER_TIMEOUT_EN to discard a partial long
// command after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   spi_cs_n, spi_sclk, spi_mosi  SPI slave inputs (async to clk)
//   opcode, opdata                last completed command
//   execute                       one-cycle strobe, opcode/opdata valid
//   busy                          long command partially received
//
// state     | meaning
// ST_OPCODE | waiting for an opcode byte
// ST_ARG0   | long opcode held, waiting for argument bits [7:0]
// ST_ARG1   | waiting for argument bits [15:8]
// ST_ARG2   | waiting for argument bits [23:16]
// ST_ARG3   | waiting for argument bits [31:24], then execute
module spi_receiver
    import spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_cs_n,
    input  logic                   spi_sclk,
    input  logic                   spi_mosi,
    output logic [7:0]             opcode,
    output logic [8*ARG_BYTES-1:0] opdata,
    output logic                   execute,
    output logic                   busy
);

    logic [7:0]                 w_byte;
    logic                       w_byte_valid;
    logic                       w_timeout;
    cmd_state_e                 r_state;
    logic [7:0]                 r_op_lat;
    logic [8*(ARG_BYTES-1)-1:0] r_arg;
    logic [7:0]                 r_opcode;
    logic [8*ARG_BYTES-1:0]     r_opdata;
    logic                       r_execute;
    logic                       r_busy;

    spi_rx_byte u_rx_byte (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cs_n       (spi_cs_n),
        .i_sclk       (spi_sclk),
        .i_mosi       (spi_mosi),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid)
    );

`ifdef SPI_RECEIVER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state != ST_OPCODE) && !w_byte_valid &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_byte_valid || r_state == ST_OPCODE || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OPCODE;
            r_op_lat  <= 8'd0;
            r_arg     <= '0;
            r_opcode  <= 8'd0;
            r_opdata  <= '0;
            r_execute <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_execute <= 1'b0;
            if (w_byte_valid) begin
                case (r_state)
                    ST_OPCODE: begin
                        if (w_byte[LONG_BIT]) begin
                            r_op_lat <= w_byte;
                            r_state  <= ST_ARG0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_opcode  <= w_byte;
                            r_opdata  <= '0;
                            r_execute <= 1'b1;
                        end
                    end
                    ST_ARG0: begin
                        r_arg[7:0] <= w_byte;
                        r_state    <= ST_ARG1;
                    end
                    ST_ARG1: begin
                        r_arg[15:8] <= w_byte;
                        r_state     <= ST_ARG2;
                    end
                    ST_ARG2: begin
                        r_arg[23:16] <= w_byte;
                        r_state      <= ST_ARG3;
                    end
                    ST_ARG3: begin
                        r_opcode  <= r_op_lat;
                        r_opdata  <= {w_byte, r_arg};
                        r_execute <= 1'b1;
                        r_state   <= ST_OPCODE;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_OPCODE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_timeout) begin
                r_state <= ST_OPCODE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign opcode  = r_opcode;
    assign opdata  = r_opdata;
    assign execute = r_execute;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_receiver.sv
module tb_spi_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic [7:0]  opcode;
    logic [31:0] opdata;
    logic        execute;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] exp_q[$];
    logic [39:0] exp_last = 40'd0;

    localparam int HALF = 40; // SCLK half period = 4 clk periods

    always #5 clk = ~clk;

    spi_receiver #(.TIMEOUT_CYCLES(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .opcode   (opcode),
        .opdata   (opdata),
        .execute  (execute),
        .busy     (busy)
    );

    // Scoreboard consumer: every execute pops one expected command; between
    // executes the outputs must hold the last completed command.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_last = 40'd0;
        end else if (execute) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_execute: got op=%02h data=%08h, required no execute",
                         opcode, opdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({opcode, opdata} !== e) begin
                    n_err++;
                    $display("FAIL execute_value: got op=%02h data=%08h, required op=%02h data=%08h",
                             opcode, opdata, e[39:32], e[31:0]);
                end
                exp_last = e;
            end
        end else begin
            n_vec++;
            if ({opcode, opdata} !== exp_last) begin
                n_err++;
                if (n_err < 20)
                    $display("FAIL output_hold: got op=%02h data=%08h, required op=%02h data=%08h",
                             opcode, opdata, exp_last[39:32], exp_last[31:0]);
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs_n = 1'b1;
        #HALF;
    endtask

    task automatic send_frame(input logic [7:0] b);
        cs_low();
        send_bits(b, 8);
        cs_high();
    endtask

    task automatic check_busy(input string name, input logic req);
        @(negedge clk);
        n_vec++;
        if (busy !== req) begin
            n_err++;
            $display("FAIL %s: busy got %b, required %b", name, busy, req);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d executes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if ({opcode, opdata, execute, busy} !== 42'd0) begin
                n_err++;
                $display("FAIL reset_state: got op=%02h data=%08h exe=%b busy=%b, required all 0",
                         opcode, opdata, execute, busy);
            end
        end
    endtask

    task automatic test_short();
        exp_q.push_back({8'h02, 32'h0});
        send_frame(8'h02);
        check_busy("short_busy", 1'b0);
        drain("short_cmd");
    endtask

    task automatic test_long();
        exp_q.push_back({8'h80, 32'h44332211});
        cs_low();
        send_bits(8'h80, 8);
        check_busy("long_busy_hi", 1'b1);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        check_busy("long_busy_arg3", 1'b1);
        send_bits(8'h44, 8);
        cs_high();
        drain("long_cmd");
        check_busy("long_busy_lo", 1'b0);
    endtask

    task automatic test_cs_framing();
        cs_low();
        send_bits(8'hF0, 4);
        cs_high();
        exp_q.push_back({8'h01, 32'h0});
        send_frame(8'h01);
        drain("cs_partial_byte");
        exp_q.push_back({8'h80, 32'h44332211});
        send_frame(8'h80);
        check_busy("frame_busy_hi", 1'b1);
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        send_frame(8'h44);
        drain("cs_per_byte_long");
        check_busy("frame_busy_lo", 1'b0);
    endtask

    task automatic test_reset_mid();
        send_frame(8'h80);
        send_frame(8'h11);
        send_frame(8'h22);
        check_busy("rstmid_busy_hi", 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_busy("rstmid_busy_lo", 1'b0);
        exp_q.push_back({8'h00, 32'h0});
        send_frame(8'h00);
        drain("rstmid_cmd");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({8'h01, 32'h0});
        exp_q.push_back({8'h80, 32'hDDCCBBAA});
        exp_q.push_back({8'h02, 32'h0});
        cs_low();
        send_bits(8'h01, 8);
        send_bits(8'h80, 8);
        send_bits(8'hAA, 8);
        send_bits(8'hBB, 8);
        send_bits(8'hCC, 8);
        send_bits(8'hDD, 8);
        send_bits(8'h02, 8);
        cs_high();
        drain("back_to_back");
    endtask

`ifdef SPI_RECEIVER_TIMEOUT_EN
    task automatic test_timeout();
        send_frame(8'h80);
        check_busy("timeout_busy_hi", 1'b1);
        repeat (70) @(negedge clk);
        check_busy("timeout_busy_lo", 1'b0);
        exp_q.push_back({8'h01, 32'h0});
        send_frame(8'h01);
        drain("timeout_next_short");
    endtask
`endif

    initial begin
        test_reset();
        test_short();
        test_long();
        test_cs_framing();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_RECEIVER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
